// File: rtl/output_col_if.sv
// Column sink bus: upstream column handshake plus the RAM-style beat write port.
interface output_col_if #(
  parameter int W    = 8,
  parameter int ROWS = 256,
  parameter int WPB  = 4,
  parameter int AW   = 14
) ();
  logic                   data_rdy_in;
  logic                   last_col_in;
  logic [ROWS-1:0][W-1:0] data_in;
  logic                   data_req_out;
  logic                   wr_en;
  logic                   wr_ready;
  logic [AW-1:0]          wr_addr;
  logic [W*WPB-1:0]       wr_data;

  modport master (
    output data_rdy_in, last_col_in, data_in, wr_ready,
    input  data_req_out, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  data_rdy_in, last_col_in, data_in, wr_ready,
    output data_req_out, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/output_col.sv
// Terminal column sink: captures one column, writes it out as WPB-pixel beats,
// counts columns and flags frame completion / last-marker mismatch.
module output_col #(
  parameter int W    = 8,
  parameter int ROWS = 256,
  parameter int COLS = 256,
  parameter int WPB  = 4,
  parameter int AW   = 14
) (
  input  logic                       clock,
  input  logic                       init,
  output_col_if.slave                bus,
  output logic [$clog2(COLS+1)-1:0]  col_count,
  output logic                       frame_done,
  output logic                       err_out
);
  localparam int BPC = ROWS / WPB;
  localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int CW  = $clog2(COLS + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  state_e                           state_q, state_d;
  // Viewed beat-major so a beat is a plain index; row order is unchanged.
  logic [BPC-1:0][WPB-1:0][W-1:0]   buf_q, buf_d;
  logic [BW-1:0]                    beat_q, beat_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             last_q, last_d;
  logic                             err_q, err_d;
  logic                             last_idx;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    err_d    = err_q;
    last_idx = (cnt_q == CW'(COLS - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.data_rdy_in) begin
          buf_d   = bus.data_in;
          last_d  = bus.last_col_in;
          beat_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.wr_ready) begin
          if (beat_q == BW'(BPC - 1)) begin
            if (cnt_q != CW'(COLS)) cnt_d = cnt_q + CW'(1);
            // Marker and position must agree: last column iff index COLS-1.
            err_d   = err_q | (last_idx != last_q);
            state_d = (last_q || last_idx) ? DONE : IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the column buffer is ordinary flops and is cleared on reset so wr_data reads zero out of reset.
  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      state_q <= IDLE;
      buf_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_req_out = (state_q == IDLE);
  assign bus.wr_en        = (state_q == WRITE);
  assign bus.wr_data      = buf_q[beat_q];
  assign bus.wr_addr      = AW'(cnt_q) * AW'(BPC) + AW'(beat_q);
  assign col_count        = cnt_q;
  assign frame_done       = (state_q == DONE);
  assign err_out          = err_q;
endmodule

// File: tb/tb_output_col.sv
// Self-checking bench for output_col: randomized columns and stalls checked
// against a beat-list / column-count reference model.
module tb_output_col;
  localparam int W    = 8;
  localparam int ROWS = 256;
  localparam int COLS = 256;
  localparam int WPB  = 4;
  localparam int AW   = 14;
  localparam int BPC  = ROWS / WPB;
  localparam int CW   = $clog2(COLS + 1);

  logic          clock = 1'b0;
  logic          init  = 1'b1;
  logic [CW-1:0] col_count;
  logic          frame_done;
  logic          err_out;

  output_col_if #(.W(W), .ROWS(ROWS), .WPB(WPB), .AW(AW)) bus ();

  output_col #(.W(W), .ROWS(ROWS), .COLS(COLS), .WPB(WPB), .AW(AW)) dut (
    .clock      (clock),
    .init       (init),
    .bus        (bus),
    .col_count  (col_count),
    .frame_done (frame_done),
    .err_out    (err_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference model: columns completed, sticky error, frame done.
  int m_cols;
  bit m_err;
  bit m_done;

  logic [ROWS-1:0][W-1:0] col_px;
  logic [W*WPB-1:0]       first_data, last_data;
  logic [AW-1:0]          last_addr;
  int                     wcycles;

  task automatic model_reset();
    m_cols = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    init            = 1'b1;
    bus.data_rdy_in = 1'b0;
    bus.last_col_in = 1'b0;
    bus.wr_ready    = 1'b1;
    repeat (2) @(negedge clock);
    init = 1'b0;
    model_reset();
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++) col_px[r] = W'($urandom);
  endtask

  // Presents col_px, follows the beats with the given wr_ready pattern
  // (0: always ready, 1: low on even cycles, 2: random), optionally
  // asserting init when beat abort_beat is on the bus.
  task automatic send_column(input bit last, input int mode, input int abort_beat);
    int b, cyc, waitc;
    logic [W*WPB-1:0] exp_d;
    logic [AW-1:0]    exp_a;
    bit               was_last_idx;
    waitc = 0;
    while (bus.data_req_out !== 1'b1 && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    checks++;
    if (bus.data_req_out !== 1'b1) begin
      $display("FAIL req_wait: data_req_out=%b after %0d cycles, required 1", bus.data_req_out, waitc);
      return;
    end else passed++;

    bus.data_in     = col_px;
    bus.last_col_in = last;
    bus.data_rdy_in = 1'b1;
    @(negedge clock);
    bus.data_rdy_in = 1'b0;
    bus.last_col_in = 1'($urandom_range(1, 0));
    bus.data_in     = ~col_px;
    checks++;
    if (bus.data_req_out !== 1'b0) $display("FAIL req_after_capture: got %b, required 0", bus.data_req_out);
    else passed++;

    b = 0;
    cyc = 0;
    while (b < BPC && cyc < 4 * BPC + 8) begin
      exp_a = AW'(m_cols * BPC + b);
      for (int j = 0; j < WPB; j++) exp_d[j*W +: W] = col_px[b*WPB + j];
      checks++;
      if (bus.wr_en !== 1'b1) $display("FAIL wr_en col%0d beat%0d: got %b, required 1", m_cols, b, bus.wr_en);
      else passed++;
      checks++;
      if (bus.wr_addr !== exp_a) $display("FAIL wr_addr col%0d beat%0d: got %0d, required %0d", m_cols, b, bus.wr_addr, exp_a);
      else passed++;
      checks++;
      if (bus.wr_data !== exp_d) $display("FAIL wr_data col%0d beat%0d: got %h, required %h", m_cols, b, bus.wr_data, exp_d);
      else passed++;
      if (b == 0) first_data = bus.wr_data;

      if (b == abort_beat) begin
        init = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0) $display("FAIL abort_wr_en: got %b, required 0", bus.wr_en); else passed++;
        checks++;
        if (bus.data_req_out !== 1'b1) $display("FAIL abort_req: got %b, required 1", bus.data_req_out); else passed++;
        checks++;
        if (bus.wr_addr !== '0 || bus.wr_data !== '0)
          $display("FAIL abort_bus: got addr %0d data %h, required 0 0", bus.wr_addr, bus.wr_data);
        else passed++;
        checks++;
        if (col_count !== '0 || frame_done !== 1'b0 || err_out !== 1'b0)
          $display("FAIL abort_status: got cnt %0d done %b err %b, required 0 0 0", col_count, frame_done, err_out);
        else passed++;
        @(negedge clock);
        init = 1'b0;
        bus.wr_ready = 1'b1;
        model_reset();
        return;
      end

      case (mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = (cyc % 2 == 1);
        default: bus.wr_ready = ($urandom_range(3, 0) != 0);
      endcase
      if (bus.wr_ready && bus.wr_en === 1'b1) begin
        last_data = bus.wr_data;
        last_addr = bus.wr_addr;
        b++;
      end
      @(negedge clock);
      cyc++;
    end
    bus.wr_ready = 1'b1;
    wcycles = cyc;
    checks++;
    if (b != BPC) $display("FAIL beat_timeout col%0d: got %0d beats, required %0d", m_cols, b, BPC);
    else passed++;

    was_last_idx = (m_cols == COLS - 1);
    if (was_last_idx != last) m_err = 1'b1;
    if (last || was_last_idx) m_done = 1'b1;
    m_cols++;

    checks++;
    if (bus.wr_en !== 1'b0 || bus.data_req_out !== !m_done || frame_done !== m_done)
      $display("FAIL end_state col%0d: got wr_en %b req %b done %b, required 0 %b %b",
               m_cols - 1, bus.wr_en, bus.data_req_out, frame_done, !m_done, m_done);
    else passed++;
    checks++;
    if (col_count !== CW'(m_cols)) $display("FAIL col_count: got %0d, required %0d", col_count, m_cols);
    else passed++;
    checks++;
    if (err_out !== m_err) $display("FAIL err_out col%0d: got %b, required %b", m_cols - 1, err_out, m_err);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.data_req_out !== 1'b1 || bus.wr_en !== 1'b0 || frame_done !== 1'b0 || err_out !== 1'b0)
      $display("FAIL reset_ctrl: got req %b wr_en %b done %b err %b, required 1 0 0 0",
               bus.data_req_out, bus.wr_en, frame_done, err_out);
    else passed++;
    checks++;
    if (bus.wr_addr !== '0 || bus.wr_data !== '0 || col_count !== '0)
      $display("FAIL reset_data: got addr %0d data %h cnt %0d, required 0 0 0", bus.wr_addr, bus.wr_data, col_count);
    else passed++;
  endtask

  task automatic test_single_column();
    do_reset();
    for (int r = 0; r < ROWS; r++) col_px[r] = W'(r);
    send_column(1'b0, 0, -1);
    checks++;
    if (first_data !== 32'h0302_0100) $display("FAIL single_beat0: got %h, required 03020100", first_data); else passed++;
    checks++;
    if (last_data !== 32'hFFFE_FDFC) $display("FAIL single_beat63: got %h, required fffefdfc", last_data); else passed++;
    checks++;
    if (last_addr !== AW'(63)) $display("FAIL single_last_addr: got %0d, required 63", last_addr); else passed++;
    checks++;
    if (wcycles != 64) $display("FAIL single_cycles: got %0d, required 64", wcycles); else passed++;
    checks++;
    if (col_count !== CW'(1)) $display("FAIL single_count: got %0d, required 1", col_count); else passed++;
  endtask

  task automatic test_backpressure();
    fill_random();
    send_column(1'b0, 1, -1);
    checks++;
    if (wcycles != 128) $display("FAIL bp_cycles: got %0d, required 128", wcycles); else passed++;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      send_column(1'b0, 2, -1);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (bus.wr_en !== 1'b0 || bus.data_req_out !== 1'b1 || err_out !== 1'b0)
        $display("FAIL idle_hold cycle%0d: got wr_en %b req %b err %b, required 0 1 0", i, bus.wr_en, bus.data_req_out, err_out);
      else passed++;
      bus.last_col_in = i[0];
      @(negedge clock);
    end
    checks++;
    if (col_count !== '0) $display("FAIL idle_count: got %0d, required 0", col_count); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      fill_random();
      send_column(1'b0, 0, -1);
    end
    fill_random();
    send_column(1'b0, 0, 30);
    fill_random();
    send_column(1'b0, 0, -1);
    checks++;
    if (col_count !== CW'(1) || last_addr !== AW'(BPC - 1))
      $display("FAIL post_reset_col: got cnt %0d last_addr %0d, required 1 %0d", col_count, last_addr, BPC - 1);
    else passed++;
  endtask

  task automatic test_ignored_after_done();
    for (int i = 0; i < 8; i++) begin
      bus.data_rdy_in = 1'b1;
      bus.last_col_in = 1'($urandom_range(1, 0));
      @(negedge clock);
      checks++;
      if (bus.wr_en !== 1'b0 || bus.data_req_out !== 1'b0 || frame_done !== 1'b1 || col_count !== CW'(m_cols))
        $display("FAIL done_hold cycle%0d: got wr_en %b req %b done %b cnt %0d, required 0 0 1 %0d",
                 i, bus.wr_en, bus.data_req_out, frame_done, col_count, m_cols);
      else passed++;
    end
    bus.data_rdy_in = 1'b0;
  endtask

  task automatic test_early_last();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      fill_random();
      send_column(c == 9, 2, -1);
    end
    checks++;
    if (col_count !== CW'(10) || err_out !== 1'b1 || frame_done !== 1'b1)
      $display("FAIL early_last: got cnt %0d err %b done %b, required 10 1 1", col_count, err_out, frame_done);
    else passed++;
    test_ignored_after_done();
  endtask

  task automatic test_full_frame(input bit mark_last);
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      fill_random();
      send_column(mark_last && (c == COLS - 1), 0, -1);
    end
    checks++;
    if (last_addr !== AW'(16383)) $display("FAIL frame_last_addr: got %0d, required 16383", last_addr); else passed++;
    checks++;
    if (col_count !== CW'(256) || frame_done !== 1'b1 || err_out !== !mark_last)
      $display("FAIL frame_end: got cnt %0d done %b err %b, required 256 1 %b", col_count, frame_done, err_out, !mark_last);
    else passed++;
    test_ignored_after_done();
  endtask

  initial begin
    bus.data_rdy_in = 1'b0;
    bus.last_col_in = 1'b0;
    bus.data_in     = '0;
    bus.wr_ready    = 1'b1;
    model_reset();
    test_reset();
    test_single_column();
    test_backpressure();
    test_idle_hold();
    test_reset_mid();
    test_early_last();
    test_full_frame(1'b1);
    test_full_frame(1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
